// File: rtl/pwm_capture_if.sv
// PWM capture bus: the measured pin and its results.
// master drives the pin, slave measures it.
interface pwm_capture_if #(
  parameter int W = 32
);
  logic         pin;
  logic [W-1:0] period;
  logic [W-1:0] high;
  logic [6:0]   duty;
  logic         valid;
  logic         stuck;
  logic         stuck_level;
  logic         overrun;

  modport master (
    output pin,
    input  period, high, duty, valid,
    input  stuck, stuck_level, overrun
  );

  modport slave (
    input  pin,
    output period, high, duty, valid,
    output stuck, stuck_level, overrun
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM period / high-time / duty measurement.
// Rise-to-rise counting, 7-step restoring duty divider.
module pwm_capture #(
  parameter int F       = 50_000_000,
  parameter int W       = 32,
  parameter int TIMEOUT = F
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.slave  bus
);

  localparam int RW = W + 7;
  localparam logic [W-1:0] TO    = W'(TIMEOUT);
  localparam logic [W-1:0] TO_M1 = W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  state_t         state_q, state_d;
  logic           s1_q, s1_d;
  logic           s2_q, s2_d;
  logic           p_q, p_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   hi_lat_q, hi_lat_d;
  logic [W-1:0]   idle_q, idle_d;
  logic           stuck_q, stuck_d;
  logic           lvl_q, lvl_d;
  logic           ovr_q, ovr_d;
  logic           busy_q, busy_d;
  logic [2:0]     step_q, step_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [W-1:0]   per_q, per_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [6:0]     quo_q, quo_d;
  logic [W-1:0]   period_q, period_d;
  logic [W-1:0]   high_q, high_d;
  logic [6:0]     duty_q, duty_d;
  logic           valid_q, valid_d;

  logic           rise, fall, edge_any;
  logic           timeout;
  logic           complete;
  logic           accept;
  logic           drop;
  logic           last;
  logic [RW-1:0]  shifted;
  logic           ge;
  logic [6:0]     quo_step;

  // Synchroniser, edge detect and no-edge watchdog.
  always_comb begin
    s1_d     = bus.pin;
    s2_d     = s1_q;
    p_d      = s2_q;
    rise     = s2_q & ~p_q;
    fall     = ~s2_q & p_q;
    edge_any = rise | fall;
    timeout  = ~edge_any & (idle_q >= TO_M1);
    idle_d   = idle_q;
    if (edge_any) begin
      idle_d = '0;
    end else if (idle_q != TO) begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Measurement FSM: counts rise-to-rise, latches high time on fall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_lat_d = hi_lat_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = W'(1);
          state_d = MEAS;
        end
      end
      MEAS: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (fall) begin
          hi_lat_d = cnt_q;
        end
        if (rise) begin
          complete = 1'b1;
          cnt_d    = W'(1);
        end
      end
    endcase
    if (timeout) begin
      state_d  = IDLE;
      cnt_d    = '0;
      hi_lat_d = '0;
    end
  end

  // Restoring divider: quotient bit per cycle, MSB first.
  always_comb begin
    accept   = complete & ~busy_q;
    drop     = complete & busy_q;
    last     = busy_q & (step_q == 3'd0);
    shifted  = RW'(per_q) << step_q;
    ge       = (rem_q >= shifted);
    quo_step = quo_q;
    quo_step[step_q] = ge;
    busy_d   = busy_q;
    step_d   = step_q;
    rem_d    = rem_q;
    per_d    = per_q;
    hi_d     = hi_q;
    quo_d    = quo_q;
    if (busy_q) begin
      rem_d  = ge ? rem_q - shifted : rem_q;
      quo_d  = quo_step;
      step_d = step_q - 3'd1;
      if (step_q == 3'd0) begin
        busy_d = 1'b0;
      end
    end
    if (accept) begin
      busy_d = 1'b1;
      step_d = 3'd6;
      rem_d  = RW'(hi_lat_q) * RW'(7'd100);
      per_d  = cnt_q;
      hi_d   = hi_lat_q;
      quo_d  = '0;
    end
  end

  // Result registers, stuck flag and sticky overrun.
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    duty_d   = duty_q;
    valid_d  = last;
    stuck_d  = stuck_q;
    lvl_d    = lvl_q;
    ovr_d    = ovr_q | drop;
    if (last) begin
      period_d = per_q;
      high_d   = hi_q;
      duty_d   = quo_step;
    end
    unique case (1'b1)
      rise:    stuck_d = 1'b0;
      timeout: begin
        stuck_d = 1'b1;
        lvl_d   = s2_q;
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      p_q      <= 1'b0;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      idle_q   <= '0;
      stuck_q  <= 1'b0;
      lvl_q    <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
      step_q   <= '0;
      rem_q    <= '0;
      per_q    <= '0;
      hi_q     <= '0;
      quo_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
      idle_q   <= idle_d;
      stuck_q  <= stuck_d;
      lvl_q    <= lvl_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
      rem_q    <= rem_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      quo_q    <= quo_d;
      period_q <= period_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.period      = period_q;
  assign bus.high        = high_q;
  assign bus.duty        = duty_q;
  assign bus.valid       = valid_q;
  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = lvl_q;
  assign bus.overrun     = ovr_q;

endmodule
